// File: rtl/quan_shift_round_clamp_serializer.sv
// Requantization stage: captures one bias-added vector, applies a rounding
// arithmetic right shift, saturates each lane to int8 or int16, packs the
// result into 512 bits and streams it out as four 128-bit beats.
module quan_shift_round_clamp_serializer (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    mode,
    input  logic [5:0]    shift_amt,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2559:0] in_vector,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [1:0]    out_beat_idx,
    output logic          out_last
);

    localparam int unsigned ColumnNumInSa    = 16;
    localparam int unsigned PeParallelPixel  = 2;
    localparam int unsigned PeParallelWeight = 2;
    localparam int unsigned MultPWidth       = 40;
    localparam int unsigned LaneNum          = ColumnNumInSa * PeParallelPixel * PeParallelWeight;
    localparam int unsigned OutBeatWidth     = 128;
    localparam int unsigned PackedWidth      = 512;

    typedef enum logic [1:0] {StIdle, StCalc, StSend} state_e;

    state_e                          state_q, state_d;
    logic [LaneNum*MultPWidth-1:0]   vec_q;
    logic [3:0]                      mode_q;
    logic [5:0]                      shift_q;
    logic [PackedWidth-1:0]          packed_q, packed_d;
    logic [1:0]                      beat_q, beat_d;
    logic                            capture;

    // Rounding (half-up) arithmetic right shift; 41 bits so the rounding add cannot overflow.
    function automatic logic signed [40:0] round_shift(input logic [39:0] x,
                                                       input logic [5:0]  amt);
        logic [5:0]         s;
        logic signed [40:0] xe;
        logic signed [40:0] half;
        s  = (amt > 6'd39) ? 6'd39 : amt;
        xe = {x[39], x};
        if (s == 6'd0) begin
            return xe;
        end
        half = 41'sd1 <<< (s - 6'd1);
        return (xe + half) >>> s;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [40:0] y);
        if (y > 41'sd127) return 8'h7f;
        if (y < -41'sd128) return 8'h80;
        return y[7:0];
    endfunction

    function automatic logic [15:0] sat16(input logic signed [40:0] y);
        if (y > 41'sd32767) return 16'h7fff;
        if (y < -41'sd32768) return 16'h8000;
        return y[15:0];
    endfunction

    // Quantize and pack the captured vector according to the latched mode.
    always_comb begin
        packed_d = '0;
        case (mode_q)
            4'd1: begin
                for (int i = 0; i < 64; i++) begin
                    packed_d[i*8+:8] = sat8(round_shift(vec_q[i*MultPWidth+:MultPWidth], shift_q));
                end
            end
            4'd0: begin
                // Only the first 32 lanes are used for int16 output.
                for (int i = 0; i < 32; i++) begin
                    packed_d[i*16+:16] =
                        sat16(round_shift(vec_q[i*MultPWidth+:MultPWidth], shift_q));
                end
            end
            default: ;
        endcase
    end

    // Next-state logic: IDLE -> CALC (one cycle) -> SEND (four beats) -> IDLE.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                state_d = StSend;
                beat_d  = 2'd0;
            end
            StSend: begin
                if (out_ready) begin
                    if (beat_q == 2'd3) begin
                        state_d = StIdle;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                beat_d  = 2'd0;
            end
        endcase
    end

    // Output decode; data is forced to zero outside SEND.
    always_comb begin
        in_ready     = (state_q == StIdle);
        out_valid    = (state_q == StSend);
        out_beat_idx = beat_q;
        out_last     = out_valid && (beat_q == 2'd3);
        out_data     = out_valid ? packed_q[beat_q*OutBeatWidth+:OutBeatWidth] : '0;
    end

    // State, capture and pack registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            beat_q   <= 2'd0;
            vec_q    <= '0;
            mode_q   <= 4'd0;
            shift_q  <= 6'd0;
            packed_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (capture) begin
                vec_q   <= in_vector;
                mode_q  <= mode;
                shift_q <= shift_amt;
            end
            if (state_q == StCalc) begin
                packed_q <= packed_d;
            end
        end
    end

endmodule

// File: tb/tb_quan_shift_round_clamp_serializer.sv
// Self-checking bench: directed cases plus random vectors against an
// arithmetic reference model (floor division, explicit clamping).
module tb_quan_shift_round_clamp_serializer;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    mode;
    logic [5:0]    shift_amt;
    logic          in_valid;
    logic          in_ready;
    logic [2559:0] in_vector;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [1:0]    out_beat_idx;
    logic          out_last;

    int unsigned   n_checks = 0;
    int unsigned   n_fails  = 0;
    longint        lanes[64];
    logic [511:0]  exp_packed;

    quan_shift_round_clamp_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .shift_amt    (shift_amt),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vector    (in_vector),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_beat_idx (out_beat_idx),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: y = floor((x + 2^(s-1)) / 2^s), then clamp and pack.
    function automatic logic [511:0] model(input int md, input int sh);
        logic [511:0] p;
        int           s;
        int           n;
        longint       d;
        longint       num;
        longint       y;
        p = '0;
        s = (sh > 39) ? 39 : sh;
        if (md != 0 && md != 1) return p;
        n = (md == 1) ? 64 : 32;
        for (int i = 0; i < n; i++) begin
            if (s == 0) begin
                y = lanes[i];
            end else begin
                d   = longint'(1) << s;
                num = lanes[i] + d / 2;
                y   = num / d;
                if (num < 0 && (num % d) != 0) y = y - 1;
            end
            if (md == 1) begin
                if (y > 127) y = 127;
                if (y < -128) y = -128;
                p[i*8+:8] = y[7:0];
            end else begin
                if (y > 32767) y = 32767;
                if (y < -32768) y = -32768;
                p[i*16+:16] = y[15:0];
            end
        end
        return p;
    endfunction

    function automatic longint rand_lane();
        longint v;
        v = longint'({$urandom, $urandom});
        v = (v <<< 24) >>> 24;
        v = v >>> ($urandom % 40);
        return v;
    endfunction

    task automatic load(input int md, input int sh);
        for (int i = 0; i < 64; i++) in_vector[i*40+:40] = lanes[i][39:0];
        mode      = md[3:0];
        shift_amt = sh[5:0];
    endtask

    // Send one vector and check all four beats; style 0: ready, 1: 1,0,0,1 pattern, 2: random.
    task automatic run_vec(input string tag, input int style, input int md, input int sh);
        int w;
        int beat;
        int cyc;
        int pat[4];
        pat = '{1, 0, 0, 1};
        load(md, sh);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, " accept"}, 128'(in_ready), 128'd1);
        tick();
        // Disturb inputs after the handshake; the vector in flight must not change.
        in_valid  = 1'b0;
        mode      = ~mode;
        shift_amt = 6'($urandom);
        in_vector = {80{$urandom}};
        check({tag, " calc out_valid"}, 128'(out_valid), 128'd0);
        check({tag, " calc in_ready"}, 128'(in_ready), 128'd0);
        tick();
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 40) begin
            case (style)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[cyc%4][0];
                default: out_ready = 1'($urandom);
            endcase
            check({tag, " out_valid"}, 128'(out_valid), 128'd1);
            check({tag, " beat_idx"}, 128'(out_beat_idx), 128'(beat));
            check({tag, " out_last"}, 128'(out_last), 128'(beat == 3));
            check({tag, " out_data"}, out_data, exp_packed[beat*128+:128]);
            check({tag, " in_ready busy"}, 128'(in_ready), 128'd0);
            tick();
            if (out_ready) beat++;
            cyc++;
        end
        check({tag, " all beats"}, 128'(beat), 128'd4);
        check({tag, " done out_valid"}, 128'(out_valid), 128'd0);
        check({tag, " done in_ready"}, 128'(in_ready), 128'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int     acc[$];
        int     md;
        int     sh;
        int     w;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 4'd0;
        shift_amt = 6'd0;
        in_vector = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset out_data", out_data, 128'd0);
        check("reset beat_idx", 128'(out_beat_idx), 128'd0);
        check("reset out_last", 128'(out_last), 128'd0);

        // 24 / 16 = 1.5 rounds up to 2 in every int8 lane.
        for (int i = 0; i < 64; i++) lanes[i] = 24;
        exp_packed = {64{8'h02}};
        run_vec("m1_round", 0, 1, 4);

        // int8 saturation and negative rounding.
        for (int i = 0; i < 64; i++) lanes[i] = 0;
        lanes[0] = 1000;
        lanes[1] = -1000;
        lanes[2] = -3;
        exp_packed = '0;
        exp_packed[23:0] = 24'hfd807f;
        run_vec("m1_sat_s0", 0, 1, 0);
        exp_packed[23:0] = 24'hff807f;
        run_vec("m1_sat_s1", 0, 1, 1);

        // int16 mode with backpressure; upper lanes must be ignored.
        exp_packed = '0;
        for (int i = 0; i < 32; i++) begin
            lanes[i] = longint'(i) << 8;
            exp_packed[i*16+:16] = 16'(i);
        end
        for (int i = 32; i < 64; i++) lanes[i] = 64'sh7f_ffff_ffff;
        run_vec("m0_bp", 1, 0, 8);

        // Shift of 63 behaves as 39.
        for (int i = 0; i < 64; i++) lanes[i] = 0;
        lanes[0] = -(longint'(1) << 39);
        lanes[1] = (longint'(1) << 39) - 1;
        exp_packed = '0;
        exp_packed[31:0] = 32'h0001_ffff;
        run_vec("m0_shift63", 0, 0, 63);

        // Unsupported mode gives four zero beats.
        for (int i = 0; i < 64; i++) lanes[i] = rand_lane();
        exp_packed = '0;
        run_vec("mode5", 2, 5, 3);

        // Random vectors against the model.
        for (int t = 0; t < 12; t++) begin
            case (t % 5)
                0, 3:    md = 0;
                1, 2:    md = 1;
                default: md = int'($urandom % 16);
            endcase
            sh = int'($urandom % 64);
            for (int i = 0; i < 64; i++) lanes[i] = rand_lane();
            exp_packed = model(md, sh);
            run_vec("random", 2, md, sh);
        end

        // Continuous in_valid with out_ready high: one accept every 6 cycles.
        for (int i = 0; i < 64; i++) lanes[i] = rand_lane();
        load(1, 5);
        exp_packed = model(1, 5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) acc.push_back(c);
            if (out_valid && c < 6) check("stream data", out_data, exp_packed[(c-2)*128+:128]);
            tick();
        end
        check("stream accepts", 128'(acc.size()), 128'd4);
        for (int i = 1; i < acc.size(); i++) begin
            check("stream period", 128'(acc[i] - acc[i-1]), 128'd6);
        end
        in_valid = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check("stream drain", 128'(in_ready), 128'd1);

        // Reset during SEND discards the remaining beats.
        for (int i = 0; i < 64; i++) lanes[i] = 24;
        load(1, 4);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rst pre beat_idx", 128'(out_beat_idx), 128'd1);
        reset = 1'b1;
        tick();
        check("rst out_valid", 128'(out_valid), 128'd0);
        check("rst in_ready", 128'(in_ready), 128'd1);
        check("rst out_data", out_data, 128'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("rst no beats", 128'(out_valid), 128'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
